// File: rtl/conv_pkg.sv
// ============================================================================
// Module : conv_pkg
// Brief  : Shared geometry, widths and FSM encoding for the conv stream driver
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package conv_pkg;

  localparam int IFM_DIM = 7;
  localparam int K_DIM   = 3;
  localparam int DATA_W  = 16;
  localparam int OUT_W   = 36;

  localparam int N_IFM   = IFM_DIM * IFM_DIM;
  localparam int N_W     = K_DIM * K_DIM;
  localparam int OFM_DIM = IFM_DIM - K_DIM + 1;
  localparam int N_OFM   = OFM_DIM * OFM_DIM;

  localparam int ADDR_W  = 6;
  localparam int RES_W   = 5;

  // Sized limits so index comparisons stay width-matched
  localparam logic [ADDR_W-1:0] IFM_LIMIT = ADDR_W'(N_IFM);
  localparam logic [ADDR_W-1:0] IFM_LAST  = ADDR_W'(N_IFM - 1);
  localparam logic [ADDR_W-1:0] W_LIMIT   = ADDR_W'(N_W);
  localparam logic [RES_W-1:0]  OFM_LIMIT = RES_W'(N_OFM);
  localparam logic [RES_W-1:0]  OFM_LAST  = RES_W'(N_OFM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/conv_result_buf.sv
// ============================================================================
// Module : conv_result_buf
// Brief  : OFM capture buffer, write-on-capture with fill count, registered read
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module conv_result_buf
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_wr_en,
  input  logic [OUT_W-1:0] i_wr_data,
  input  logic [RES_W-1:0] i_rd_addr,
  output logic [RES_W-1:0] o_cnt,
  output logic             o_full,
  output logic [OUT_W-1:0] o_rd_data
);

  logic [OUT_W-1:0] r_mem [N_OFM];

  assign o_full = (o_cnt == OFM_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cnt     <= '0;
      o_rd_data <= '0;
      for (int i = 0; i < N_OFM; i++) r_mem[i] <= '0;
    end else begin
      if (i_clr) begin
        o_cnt <= '0;
      end else if (i_wr_en && !o_full) begin
        r_mem[o_cnt] <= i_wr_data;
        o_cnt        <= o_cnt + RES_W'(1);
      end
      o_rd_data <= (i_rd_addr < OFM_LIMIT) ? r_mem[i_rd_addr] : '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_stream_driver.sv
// ============================================================================
// Module : conv_stream_driver
// Brief  : Streams preloaded IFM/weights to the conv engine and collects OFM
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module conv_stream_driver
  import conv_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic [RES_W-1:0]  res_cnt,
  input  logic [RES_W-1:0]  res_addr,
  output logic [OUT_W-1:0]  res_rdata,
  output logic              in_valid,
  output logic              weight_valid,
  output logic [DATA_W-1:0] In_IFM_1,
  output logic [DATA_W-1:0] In_Weight_1,
  input  logic              out_valid,
  input  logic [OUT_W-1:0]  Out_OFM
);

  localparam int                IDLE_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYC);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_idx;
  logic [IDLE_W-1:0]   r_idle;
  logic [DATA_W-1:0]   r_ifm [N_IFM];
  logic [DATA_W-1:0]   r_w   [N_W];
  logic                w_start_acc;
  logic                w_timeout;
  logic                w_cap;
  logic                w_full;
  logic                w_send;
  logic                w_w_issue;

  assign w_send    = (r_state == SEND);
  assign w_w_issue = w_send && (r_idx < W_LIMIT);
  assign w_cap     = (r_state == WAIT) && out_valid && !w_full;

  always_comb begin
    w_next      = r_state;
    w_start_acc = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next      = SEND;
          w_start_acc = 1'b1;
        end
      end
      SEND: begin
        if (r_idx == IFM_LAST) w_next = WAIT;
      end
      WAIT: begin
        // A final capture wins over a coincident timeout
        if (w_cap && (res_cnt == OFM_LAST)) begin
          w_next = DONE;
        end else if (r_idle == IDLE_LIMIT) begin
          w_next    = DONE;
          w_timeout = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_idle  <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_acc) begin
        r_idx <= '0;
      end else if (w_send) begin
        r_idx <= r_idx + ADDR_W'(1);
      end
      if ((r_state != WAIT) || out_valid) begin
        r_idle <= '0;
      end else if (r_idle != IDLE_LIMIT) begin
        r_idle <= r_idle + IDLE_W'(1);
      end
    end
  end

  // busy/done follow the next state so they line up exactly with the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      err_timeout  <= 1'b0;
      in_valid     <= 1'b0;
      weight_valid <= 1'b0;
      In_IFM_1     <= '0;
      In_Weight_1  <= '0;
    end else begin
      busy         <= (w_next == SEND) || (w_next == WAIT);
      done         <= (w_next == DONE);
      if (w_start_acc) begin
        err_timeout <= 1'b0;
      end else if (w_timeout) begin
        err_timeout <= 1'b1;
      end
      in_valid     <= w_send;
      weight_valid <= w_w_issue;
      In_IFM_1     <= w_send    ? r_ifm[r_idx]     : '0;
      In_Weight_1  <= w_w_issue ? r_w[r_idx[3:0]]  : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IFM; i++) r_ifm[i] <= '0;
      for (int i = 0; i < N_W; i++)   r_w[i]   <= '0;
    end else if (cfg_we && !busy) begin
      if (!cfg_sel && (cfg_addr < IFM_LIMIT)) r_ifm[cfg_addr]    <= cfg_wdata;
      if (cfg_sel && (cfg_addr < W_LIMIT))    r_w[cfg_addr[3:0]] <= cfg_wdata;
    end
  end

  conv_result_buf u_res (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_start_acc),
    .i_wr_en   (w_cap),
    .i_wr_data (Out_OFM),
    .i_rd_addr (res_addr),
    .o_cnt     (res_cnt),
    .o_full    (w_full),
    .o_rd_data (res_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_conv_stream_driver.sv
// ============================================================================
// Module : tb_conv_stream_driver
// Brief  : Directed self-checking bench with a behavioural 3x3 engine model
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_conv_stream_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic        cfg_sel = 1'b0;
  logic [5:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic        start = 1'b0;
  logic        busy, done, err_timeout;
  logic [4:0]  res_cnt;
  logic [4:0]  res_addr = '0;
  logic [35:0] res_rdata;
  logic        in_valid, weight_valid;
  logic [15:0] In_IFM_1, In_Weight_1;
  logic        out_valid = 1'b0;
  logic [35:0] Out_OFM = '0;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] rx_ifm [49];
  logic [15:0] rx_w   [9];
  logic [35:0] sums   [25];
  int n_iv, n_wv, first_iv, last_iv, first_wv, bad_zero, n_done, t_done;
  logic err_t1;
  logic [35:0] v;

  conv_stream_driver #(.TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .start(start),
    .busy(busy), .done(done), .err_timeout(err_timeout), .res_cnt(res_cnt),
    .res_addr(res_addr), .res_rdata(res_rdata), .in_valid(in_valid),
    .weight_valid(weight_valid), .In_IFM_1(In_IFM_1), .In_Weight_1(In_Weight_1),
    .out_valid(out_valid), .Out_OFM(Out_OFM)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic sel, input int a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 6'(a); cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // ramp=0: all ones; ramp=1: IFM[k]=k, only centre weight set
  task automatic load_buffers(input bit ramp);
    for (int k = 0; k < 49; k++) wr(1'b0, k, ramp ? 16'(k) : 16'd1);
    for (int k = 0; k < 9; k++)  wr(1'b1, k, ramp ? ((k == 4) ? 16'd1 : 16'd0) : 16'd1);
  endtask

  task automatic rd(input int a, output logic [35:0] val);
    res_addr = 5'(a);
    tick();
    val = res_rdata;
  endtask

  task automatic engine_model();
    logic [35:0] acc;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        acc = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            acc += 36'(rx_ifm[(r+i)*7 + c + j]) * 36'(rx_w[i*3 + j]);
        sums[r*5 + c] = acc;
      end
  endtask

  // One start plus 150 observed cycles; the engine replies with n_out words
  task automatic run(input int n_out, input bit poke);
    int p;
    p = 0; n_iv = 0; n_wv = 0; first_iv = 0; last_iv = 0; first_wv = 0;
    bad_zero = 0; n_done = 0; t_done = 0; err_t1 = 1'bx;
    start = 1'b1;
    tick();
    for (int t = 1; t <= 150; t++) begin
      start = 1'b0;
      tick();
      if (in_valid) begin
        if (n_iv == 0) first_iv = t;
        last_iv = t;
        if (n_iv < 49) rx_ifm[n_iv] = In_IFM_1;
        n_iv++;
      end else if (In_IFM_1 !== 16'd0) bad_zero++;
      if (weight_valid) begin
        if (n_wv == 0) first_wv = t;
        if (n_wv < 9) rx_w[n_wv] = In_Weight_1;
        n_wv++;
      end else if (In_Weight_1 !== 16'd0) bad_zero++;
      if (t == 1) err_t1 = err_timeout;
      if (done) begin
        n_done++;
        if (t_done == 0) t_done = t;
      end
      cfg_we = 1'b0; out_valid = 1'b0; Out_OFM = '0;
      if (poke && (t == 10 || t == 55)) start = 1'b1;
      if (poke && t == 10) begin
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 6'd0; cfg_wdata = 16'hBEEF;
      end
      if (!in_valid && n_iv >= 49 && p < n_out) begin
        if (p == 0) engine_model();
        out_valid = 1'b1;
        Out_OFM   = (p < 25) ? sums[p] : 36'hF_FFFF_FFFF;
        p++;
      end
    end
    start = 1'b0; cfg_we = 1'b0; out_valid = 1'b0; Out_OFM = '0;
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_n_iv"}, 64'(n_iv), 64'd49);
    chk({tag, "_first_iv"}, 64'(first_iv), 64'd1);
    chk({tag, "_last_iv"}, 64'(last_iv), 64'd49);
    chk({tag, "_n_wv"}, 64'(n_wv), 64'd9);
    chk({tag, "_first_wv"}, 64'(first_wv), 64'd1);
    chk({tag, "_idle_zero"}, 64'(bad_zero), 64'd0);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk("rst_res_cnt", 64'(res_cnt), 64'd0);
    chk("rst_in_valid", 64'(in_valid), 64'd0);
    chk("rst_weight_valid", 64'(weight_valid), 64'd0);
    chk("rst_ifm_bus", 64'(In_IFM_1), 64'd0);
    chk("rst_w_bus", 64'(In_Weight_1), 64'd0);
    chk("rst_rdata", 64'(res_rdata), 64'd0);

    // All ones: every OFM is 9
    load_buffers(1'b0);
    run(25, 1'b0);
    chk_stream("ones");
    chk("ones_n_done", 64'(n_done), 64'd1);
    chk("ones_err", 64'(err_timeout), 64'd0);
    chk("ones_res_cnt", 64'(res_cnt), 64'd25);
    chk("ones_busy_after", 64'(busy), 64'd0);
    for (int k = 0; k < 25; k++) begin
      rd(k, v);
      chk($sformatf("ones_res%0d", k), 64'(v), 64'd9);
    end

    // Ramp IFM, centre tap only: RES[r*5+c] = IFM[(r+1)*7+c+1]
    load_buffers(1'b1);
    run(25, 1'b0);
    chk_stream("ramp");
    rd(0, v);  chk("ramp_res0", 64'(v), 64'd8);
    rd(4, v);  chk("ramp_res4", 64'(v), 64'd12);
    rd(5, v);  chk("ramp_res5", 64'(v), 64'd15);
    rd(30, v); chk("ramp_res30", 64'(v), 64'd0);
    res_addr = 5'd24;
    chk("ramp_lat_before", 64'(res_rdata), 64'd0);
    tick();
    chk("ramp_lat_after", 64'(res_rdata), 64'd40);

    // Silent engine: WAIT entered at t=49, done at 49+64+1
    run(0, 1'b0);
    chk("to_t_done", 64'(t_done), 64'd114);
    chk("to_n_done", 64'(n_done), 64'd1);
    chk("to_err", 64'(err_timeout), 64'd1);
    chk("to_res_cnt", 64'(res_cnt), 64'd0);

    // start/cfg_we while busy are ignored; next start clears err_timeout
    run(25, 1'b1);
    chk("poke_err_cleared", 64'(err_t1), 64'd0);
    chk_stream("poke");
    chk("poke_ifm0_sent", 64'(rx_ifm[0]), 64'd0);
    chk("poke_n_done", 64'(n_done), 64'd1);
    rd(24, v); chk("poke_res24", 64'(v), 64'd40);
    run(25, 1'b0);
    chk("poke_ifm0_kept", 64'(rx_ifm[0]), 64'd0);
    rd(0, v); chk("poke_res0", 64'(v), 64'd8);

    // Asynchronous reset in the middle of SEND
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (21) tick();
    chk("mid_iv_high", 64'(in_valid), 64'd1);
    chk("mid_ifm20", 64'(In_IFM_1), 64'd20);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_iv", 64'(in_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ifm_bus", 64'(In_IFM_1), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rd(0, v); chk("mid_res_cleared", 64'(v), 64'd0);
    load_buffers(1'b0);
    run(25, 1'b0);
    chk_stream("post_rst");
    chk("post_rst_ifm0", 64'(rx_ifm[0]), 64'd1);
    rd(24, v); chk("post_rst_res24", 64'(v), 64'd9);

    // 27 words returned: only the first 25 are kept
    run(27, 1'b0);
    chk("extra_res_cnt", 64'(res_cnt), 64'd25);
    chk("extra_n_done", 64'(n_done), 64'd1);
    rd(24, v); chk("extra_res24", 64'(v), 64'd9);
    rd(0, v);  chk("extra_res0", 64'(v), 64'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
